// File: rtl/ifu_pkg.sv
// Shared IFU definitions: FSM encoding, default reset PC, opcode field slice
// and the buffered fetch entry layout.
package ifu_pkg;
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

  // opcode field handed to the control decoder
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;
endpackage

// File: rtl/ifu_fifo.sv
// Two-entry instruction buffer with a registered head; the head reads as zero
// whenever the buffer is empty.
module ifu_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] din,
  output logic [63:0] head,
  output logic [1:0]  count,
  output logic        full,
  output logic        empty
);
  logic [63:0] e1;
  logic        do_pop;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      e1    <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            head  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            e1    <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          head  <= e1;
          e1    <= '0;
          count <= count - 2'd1;
        end
        // simultaneous push/pop keeps the count; legal even when full
        2'b11: begin
          if (count == 2'd1) head <= din;
          else begin
            head <= e1;
            e1   <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: sequential fetch, redirect with stale-response drain.
// Define IFU_BYPASS_EN for a same-cycle response-to-decode path.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imReqValid,
  output logic [31:0] imReqAddr,
  input  logic        imReqReady,
  input  logic        imRespValid,
  input  logic [31:0] imRespData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic [5:0]  opcode
);
  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_t      state, state_nx;
  logic [31:0] pc, tag0, tag1;
  logic [1:0]  infl, infl_nx, stale, stale_nx, bcnt;
  logic        resp_v, discard, keep, acc, byp_take;
  logic        f_push, f_pop, f_full, f_empty;
  fetch_t      f_head;

  // a response is stale if it belongs to a request issued before a redirect
  assign resp_v     = imRespValid && (infl != 2'd0);
  assign discard    = resp_v && (redirectValid || (stale != 2'd0));
  assign keep       = resp_v && !discard;
  assign imReqValid = (state == ST_RUN) && !redirectValid &&
                      (({1'b0, infl} + {1'b0, bcnt}) < DEPTH);
  assign imReqAddr  = pc;
  assign acc        = imReqValid && imReqReady;

  always_comb begin
    infl_nx = infl;
    case ({acc, resp_v})
      2'b10:   infl_nx = infl + 2'd1;
      2'b01:   infl_nx = infl - 2'd1;
      default: ;
    endcase
    stale_nx = stale;
    if (redirectValid) stale_nx = infl - {1'b0, resp_v};
    else if (discard)  stale_nx = stale - 2'd1;
    state_nx = state;
    case (state)
      ST_BOOT:  state_nx = ST_RUN;
      ST_DRAIN: if (stale_nx == 2'd0) state_nx = ST_RUN;
      default:  ;
    endcase
    if (redirectValid) state_nx = (infl != 2'd0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      infl  <= '0;
      stale <= '0;
      tag0  <= '0;
      tag1  <= '0;
    end else begin
      state <= state_nx;
      infl  <= infl_nx;
      stale <= stale_nx;
      if (redirectValid) pc <= redirectPc & ~32'd3;
      else if (acc)      pc <= pc + 32'd4;
      // tag0 is the address of the oldest in-flight request
      case ({acc, resp_v})
        2'b10: if (infl == 2'd0) tag0 <= pc; else tag1 <= pc;
        2'b01: tag0 <= tag1;
        2'b11: begin
          if (infl == 2'd1) tag0 <= pc;
          else begin
            tag0 <= tag1;
            tag1 <= pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFU_BYPASS_EN
  logic byp;
  assign byp        = keep && f_empty;
  assign byp_take   = byp && instrReady;
  assign instrValid = !f_empty || byp;
  assign instr      = byp ? imRespData : f_head.instr;
  assign instrPc    = byp ? tag0 : f_head.pc;
`else
  assign byp_take   = 1'b0;
  assign instrValid = !f_empty;
  assign instr      = f_head.instr;
  assign instrPc    = f_head.pc;
`endif

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign f_pop  = instrValid && instrReady && !f_empty;
  assign f_push = keep && !byp_take && (!f_full || f_pop);

  ifu_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .flush (redirectValid),
    .din   ({tag0, imRespData}),
    .head  (f_head),
    .count (bcnt),
    .full  (f_full),
    .empty (f_empty)
  );
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: randomized memory/decode timing against a
// program-order model of requested and delivered addresses.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imReqValid, imReqReady, imRespValid;
  logic [31:0] imReqAddr, imRespData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instrValid, instrReady;
  logic [31:0] instr, instrPc;
  logic [5:0]  opcode;

  int errors = 0, checks = 0;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imReqValid(imReqValid), .imReqAddr(imReqAddr), .imReqReady(imReqReady),
    .imRespValid(imRespValid), .imRespData(imRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .instrPc(instrPc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  int          cyc = 0;
  logic [31:0] req_pc, exp_pc;
  int          live;
  int          lat_min = 1, lat_max = 1, redir_pct = 0;
  bit          rdy_rand = 0, ir_rand = 0, resp_rand = 0, stall = 0;
  bit          coinc_mode = 0, coinc_hit = 0, saw_wrap = 0;
  int          n_acc = 0, n_hs = 0, first_acc, first_resp, first_iv;
  logic [31:0] last_acc_addr, last_hs_pc;
  logic [31:0] acc_log[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive memory/decode, check outputs, advance the model.
  task automatic cycle();
    logic        hs, acc;
    logic [31:0] w;
    imReqReady = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    instrReady = stall ? 1'b0 : (ir_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (mq.size() > 0 && mq[0].due <= cyc && (!resp_rand || $urandom_range(0, 2) != 0)) begin
      imRespValid = 1'b1;
      imRespData  = memword(mq[0].addr);
    end else begin
      imRespValid = 1'b0;
      imRespData  = $urandom;
    end
    if (!redirectValid && redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
      redirectValid = 1'b1;
      redirectPc    = 32'h0001_0000 + $urandom_range(0, 32'hFFF);
    end
    #1;
    if (coinc_mode && !redirectValid && instrValid && instrReady && imRespValid) begin
      redirectValid = 1'b1;
      redirectPc    = 32'h0000_7A0E;
      #1;
      coinc_hit = instrValid && instrReady;
    end
    if (instrValid && first_iv < 0) first_iv = cyc;
    if (imReqValid) begin
      checks++;
      if (imReqAddr !== req_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imReqAddr, req_pc);
      end
    end
    hs = instrValid && instrReady;
    if (hs) begin
      w = memword(exp_pc);
      checks++;
      if (instrPc !== exp_pc || instr !== w || opcode !== w[31:26]) begin
        errors++;
        $display("FAIL deliver cyc=%0d got pc=%h instr=%h op=%h exp pc=%h instr=%h op=%h",
                 cyc, instrPc, instr, opcode, exp_pc, w, w[31:26]);
      end
      n_hs++;
      last_hs_pc = instrPc;
      exp_pc += 32'd4;
      live--;
    end
    acc = imReqValid && imReqReady;
    if (acc) begin
      mq.push_back('{imReqAddr, cyc + $urandom_range(lat_min, lat_max)});
      if (last_acc_addr == 32'hFFFF_FFFC && imReqAddr == 32'h0) saw_wrap = 1'b1;
      last_acc_addr = imReqAddr;
      acc_log.push_back(imReqAddr);
      if (first_acc < 0) first_acc = cyc;
      req_pc += 32'd4;
      live++;
      n_acc++;
    end
    if (imRespValid) begin
      if (first_resp < 0) first_resp = cyc;
      void'(mq.pop_front());
    end
    if (redirectValid) begin
      req_pc = redirectPc & ~32'd3;
      exp_pc = req_pc;
      live   = 0;
    end
    checks++;
    if (live > 2 || live < 0) begin
      errors++;
      $display("FAIL outstanding cyc=%0d got=%0d exp<=2", cyc, live);
    end
    @(posedge clk);
    #1;
    cyc++;
    redirectValid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imReqValid !== 1'b0 || instrValid !== 1'b0 || instr !== 32'h0 ||
        instrPc !== 32'h0 || opcode !== 6'h0) begin
      errors++;
      $display("FAIL reset_outputs got reqv=%b iv=%b instr=%h pc=%h op=%h exp all zero",
               imReqValid, instrValid, instr, instrPc, opcode);
    end
    imRespValid = 1'b0; imReqReady = 1'b0; instrReady = 1'b0; redirectValid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (imReqValid !== 1'b0 || instrValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got reqv=%b iv=%b exp 0 0", imReqValid, instrValid);
    end
    mq.delete();
    req_pc = 32'h0000_3000;
    exp_pc = 32'h0000_3000;
    live   = 0;
    rst_n  = 1'b1;
  endtask

  task automatic do_latency();
    int exp_iv_lat;
`ifdef IFU_BYPASS_EN
    exp_iv_lat = 1;
`else
    exp_iv_lat = 2;
`endif
    first_acc = -1; first_resp = -1; first_iv = -1;
    lat_min = 1; lat_max = 1; rdy_rand = 0; ir_rand = 0; resp_rand = 0; stall = 0;
    acc_log.delete();
    repeat (12) cycle();
    checks++;
    if (first_acc < 0 || first_resp != first_acc + 1 || first_iv != first_acc + exp_iv_lat) begin
      errors++;
      $display("FAIL latency got acc=%0d resp=%0d iv=%0d exp resp=acc+1 iv=acc+%0d",
               first_acc, first_resp, first_iv, exp_iv_lat);
    end
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h3000 || acc_log[1] !== 32'h3004 ||
        acc_log[2] !== 32'h3008) begin
      errors++;
      $display("FAIL first_addrs got n=%0d exp 3000 3004 3008", acc_log.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    do_latency();
  endtask

  task automatic test_stall();
    int h0;
    stall = 1;
    repeat (10) cycle();
    checks++;
    if (live != 2 || instrValid !== 1'b1) begin
      errors++;
      $display("FAIL stall_fill got live=%0d iv=%b exp 2 1", live, instrValid);
    end
    stall = 0;
    h0 = n_hs;
    repeat (20) cycle();
    checks++;
    if (n_hs - h0 < 5) begin
      errors++;
      $display("FAIL stall_resume got delivered=%0d exp>=5", n_hs - h0);
    end
  endtask

  task automatic test_redirect();
    int          h0, a0;
    logic [31:0] fa, fh;
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && mq.size() != 2; i++) cycle();
    checks++;
    if (mq.size() != 2) begin
      errors++;
      $display("FAIL redir_setup got inflight=%0d exp 2", mq.size());
    end
    lat_min = 1; lat_max = 1;
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_3403;
    cycle();
    h0 = n_hs; a0 = n_acc; fa = 32'hDEAD_BEEF; fh = 32'hDEAD_BEEF;
    repeat (30) begin
      cycle();
      if (n_acc == a0 + 1) fa = last_acc_addr;
      if (n_hs == h0 + 1)  fh = last_hs_pc;
    end
    checks++;
    if (fa !== 32'h3400 || fh !== 32'h3400) begin
      errors++;
      $display("FAIL redir_target got req=%h pc=%h exp 3400 3400", fa, fh);
    end
  endtask

  task automatic test_coincide();
    int          h0;
    logic [31:0] fh;
    ir_rand = 1; coinc_hit = 0; coinc_mode = 1;
    for (int i = 0; i < 300 && !coinc_hit; i++) cycle();
    coinc_mode = 0;
    checks++;
    if (!coinc_hit) begin
      errors++;
      $display("FAIL coincide_setup got hit=0 exp 1");
    end
    h0 = n_hs; fh = 32'hDEAD_BEEF;
    repeat (30) begin
      cycle();
      if (n_hs == h0 + 1) fh = last_hs_pc;
    end
    ir_rand = 0;
    checks++;
    if (fh !== 32'h7A0C) begin
      errors++;
      $display("FAIL coincide_next got pc=%h exp 7a0c", fh);
    end
  endtask

  task automatic test_wrap();
    saw_wrap = 0;
    redirectValid = 1'b1;
    redirectPc    = 32'hFFFF_FFF4;
    cycle();
    repeat (30) cycle();
    checks++;
    if (!saw_wrap) begin
      errors++;
      $display("FAIL pc_wrap got no fffffffc->0 step exp one");
    end
  endtask

  task automatic test_random();
    int h0;
    rdy_rand = 1; ir_rand = 1; resp_rand = 1; lat_min = 1; lat_max = 3; redir_pct = 3;
    repeat (600) cycle();
    rdy_rand = 0; ir_rand = 0; resp_rand = 0; lat_min = 1; lat_max = 1; redir_pct = 0;
    h0 = n_hs;
    repeat (20) cycle();
    checks++;
    if (n_hs - h0 < 5) begin
      errors++;
      $display("FAIL random_tail got delivered=%0d exp>=5", n_hs - h0);
    end
  endtask

  task automatic test_reset_mid();
    rdy_rand = 1; ir_rand = 1; lat_min = 1; lat_max = 2;
    repeat (25) cycle();
    // assert mid-cycle with traffic still driven
    #2;
    do_reset();
    do_latency();
  endtask

  initial begin
    rst_n = 1'b0;
    imReqReady = 1'b0; imRespValid = 1'b0; imRespData = '0;
    redirectValid = 1'b0; redirectPc = '0; instrReady = 1'b0;
    last_acc_addr = '0; last_hs_pc = '0;
    req_pc = 32'h3000; exp_pc = 32'h3000; live = 0;
    #2;
    test_reset();
    test_stall();
    test_redirect();
    test_coincide();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC: default 32'h0000_3000; address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH: default 2; instruction buffer entries, fixed at 2 in this revision.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imReqValid  out  1  fetch request to instruction memory.
REQ-006 imReqAddr  out  32  word-aligned fetch address.
REQ-007 imReqReady  in  1  memory accepts the request this cycle.
REQ-008 imRespValid  in  1  in-order response returned, at least one cycle after acceptance.
REQ-009 imRespData  in  32  fetched instruction word.
REQ-010 redirectValid  in  1  branch or jump redirect pulse from the execute/PC-select logic.
REQ-011 redirectPc  in  32  redirect target.
REQ-012 instrValid  out  1  instruction available to decode.
REQ-013 instrReady  in  1  decode consumes the instruction this cycle.
REQ-014 instr  out  32  instruction word.
REQ-015 instrPc  out  32  address of instr.
REQ-016 opcode  out  6  instr[31:26], driven straight into the control decoder.

Function
REQ-017 The request handshake SHALL complete when imReqValid && imReqReady, and the output handshake when instrValid && instrReady.
REQ-018 The FSM SHALL have three states: BOOT for one cycle after reset release then RUN; RUN; and DRAIN, entered on a redirect while requests are in flight and left for RUN when the stale count reaches 0.
REQ-019 imReqValid SHALL be asserted only in RUN, and only when in-flight count plus buffered count < BUF_DEPTH.
REQ-020 The PC SHALL advance by 4 on each accepted request, wrapping modulo 2^32 (32'hFFFF_FFFC → 32'h0).
REQ-021 The in-flight count (0..2) SHALL increment on request acceptance and decrement on imRespValid; simultaneous events SHALL leave it unchanged.
REQ-022 Each valid response SHALL be pushed into the buffer tagged with its request address, and the buffer head SHALL drive instr and instrPc.
REQ-023 On redirectValid the block SHALL:
  - flush the buffer;
  - load PC with {redirectPc[31:2],2'b00};
  - move the in-flight count into the stale counter;
  - go to DRAIN, or to RUN if the in-flight count is 0.
REQ-024 Responses arriving while the stale counter is nonzero, including one arriving in the redirect cycle itself, SHALL be discarded and SHALL decrement that counter.
REQ-025 An output handshake in the redirect cycle SHALL count as delivered, and the flush SHALL apply afterwards.
REQ-026 A request that is not accepted SHALL hold imReqAddr stable. A redirect SHALL replace the address in the following cycle.
REQ-027 Buffer full with instrReady low SHALL stall requests and SHALL NOT drop data. A push and a pop in the same cycle when full SHALL be legal.
REQ-028 Without the Configuration bypass, the minimum latency SHALL be: request accept at cycle N, response at N+1, instrValid at N+2.

Reset
REQ-029 Asserting rst_n low, at any time including mid-transfer, SHALL immediately force:
  - state BOOT, PC = RESET_PC;
  - buffer, in-flight count and stale count = 0;
  - imReqValid = 0, instrValid = 0;
  - instr = 0, instrPc = 0, opcode = 0.
REQ-030 Responses to requests issued before reset SHALL be ignored, by memory contract.

Configuration
REQ-031 The macro IFU_BYPASS_EN SHALL select the response path:
  - defined: with the buffer empty and no stale responses pending, a valid response SHALL appear on instr and instrValid in the same cycle; if instrReady is high it SHALL NOT be written to the buffer.
  - undefined: every response SHALL pass through the buffer, as in REQ-028.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the default RESET_PC, and the opcode field slice constants used together with the control decoder.
REQ-033 The buffer SHALL be a sub-module ifu_fifo: 2 entries of 64 bits (pc, instr), with push/pop/flush/full/empty and a registered head.

Verification
REQ-034 Reset release, imReqReady = 1, 1-cycle memory → imReqAddr sequence 0x3000, 0x3004, 0x3008; instrPc order matches; opcode = instr[31:26].
REQ-035 instrReady = 0 for 10 cycles → at most 2 requests outstanding or buffered; no loss on resume.
REQ-036 Redirect to 0x3403 with 2 in flight → both responses dropped; next imReqAddr = 0x3400; first delivered instrPc = 0x3400.
REQ-037 Redirect coincides with a response and an output handshake → handshaked word delivered once; response discarded; stale count correct.
REQ-038 PC at 0xFFFF_FFFC → next request 0x0000_0000.
REQ-039 rst_n low mid-transfer with IFU_BYPASS_EN both defined and undefined → outputs cleared immediately; after release, first request 0x3000; with bypass, instrValid in the same cycle as the response.
